// File: rtl/ram2.sv
// 16 x 4 single-port scratch-pad RAM: registered read port, write-first on a
// same-address write, and a synchronous active-low reset that clears every word.
module ram2 #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIN,
  output logic [DATA_WIDTH-1:0] dataOUT,
  input  logic                  WR,
  input  logic [ADDR_WIDTH-1:0] addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clearing reset needs every word on a flop, so this is a register file rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dataOUT <= '0;
    end else if (WR) begin
      mem[addr] <= dataIN;
      dataOUT   <= dataIN;
    end else begin
      dataOUT <= mem[addr];
    end
  end

endmodule

// File: tb/tb_ram2.sv
// Scoreboard bench for ram2: a reference memory predicts dataOUT for every
// driven cycle, and each scenario task pops and compares after the clock edge.
module tb_ram2;

  logic       clk;
  logic       rst;
  logic [3:0] dataIN;
  logic [3:0] dataOUT;
  logic       WR;
  logic [3:0] addr;

  logic [3:0] model [16];
  logic [3:0] exp_q [$];
  logic [3:0] exp;
  int         n_checks;
  int         n_fail;

  ram2 #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .dataIN  (dataIN),
    .dataOUT (dataOUT),
    .WR      (WR),
    .addr    (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus on the falling edge, predict the output, then
  // step past the rising edge so dataOUT can be sampled clear of it.
  task automatic drive(input logic r, input logic w, input logic [3:0] a, input logic [3:0] d);
    logic [3:0] e;
    @(negedge clk);
    rst = r; WR = w; addr = a; dataIN = d;
    if (!r) begin
      for (int i = 0; i < 16; i++) model[i] = 4'h0;
      e = 4'h0;
    end else if (w) begin
      model[a] = d;
      e = d;
    end else begin
      e = model[a];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (dataOUT !== exp) begin
      n_fail++;
      $display("FAIL reset_initial got=%h exp=%h", dataOUT, exp);
    end
    drive(1'b1, 1'b1, 4'd3, 4'hA);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b1, 4'd12, 4'h5);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b0, 4'd3, 4'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (dataOUT !== 4'h0 || dataOUT !== exp) begin
      n_fail++;
      $display("FAIL reset_edge got=%h exp=%h", dataOUT, exp);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, (k == 0) ? 4'd3 : 4'd12, 4'hF);
      exp = exp_q.pop_front();
      n_checks++;
      if (dataOUT !== 4'h0 || dataOUT !== exp) begin
        n_fail++;
        $display("FAIL reset_clear addr=%0d got=%h exp=0", addr, dataOUT);
      end
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < 2; n++) begin
        drive(1'b1, 1'b1, 4'(i), 4'(i));
        exp = exp_q.pop_front();
        n_checks++;
        if (dataOUT !== exp) begin
          n_fail++;
          $display("FAIL fill_write addr=%0d got=%h exp=%h", i, dataOUT, exp);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 4'(15 - i));
      exp = exp_q.pop_front();
      n_checks++;
      if (dataOUT !== 4'(i) || dataOUT !== exp) begin
        n_fail++;
        $display("FAIL fill_readback addr=%0d got=%h exp=%h", i, dataOUT, exp);
      end
    end
  endtask

  task automatic test_read_during_write;
    drive(1'b1, 1'b1, 4'd7, 4'h2);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 4'd7, 4'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (dataOUT !== 4'h2 || dataOUT !== exp) begin
      n_fail++;
      $display("FAIL rdw_before got=%h exp=2", dataOUT);
    end
    drive(1'b1, 1'b1, 4'd7, 4'h9);
    exp = exp_q.pop_front();
    n_checks++;
    if (dataOUT !== 4'h9 || dataOUT !== exp) begin
      n_fail++;
      $display("FAIL rdw_write_first got=%h exp=9", dataOUT);
    end
    // dataOUT must hold between edges even though the inputs move.
    addr = 4'd0; dataIN = 4'h4; WR = 1'b0;
    #2;
    n_checks++;
    if (dataOUT !== 4'h9) begin
      n_fail++;
      $display("FAIL output_stable got=%h exp=9", dataOUT);
    end
    drive(1'b1, 1'b0, 4'd7, 4'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (dataOUT !== 4'h9 || dataOUT !== exp) begin
      n_fail++;
      $display("FAIL rdw_readback got=%h exp=9", dataOUT);
    end
  endtask

  task automatic test_write_disabled;
    drive(1'b1, 1'b1, 4'd4, 4'h6);
    void'(exp_q.pop_front());
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b0, 4'd4, 4'hF);
      exp = exp_q.pop_front();
      n_checks++;
      if (dataOUT !== 4'h6 || dataOUT !== exp) begin
        n_fail++;
        $display("FAIL write_disabled cycle=%0d got=%h exp=6", n, dataOUT);
      end
    end
  endtask

  task automatic test_reset_beats_write;
    drive(1'b1, 1'b1, 4'd5, 4'h8);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 4'd5, 4'hC);
    exp = exp_q.pop_front();
    n_checks++;
    if (dataOUT !== 4'h0 || dataOUT !== exp) begin
      n_fail++;
      $display("FAIL reset_vs_write_edge got=%h exp=0", dataOUT);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, (k == 0) ? 4'd5 : ((k == 1) ? 4'd4 : 4'd15), 4'hC);
      exp = exp_q.pop_front();
      n_checks++;
      if (dataOUT !== 4'h0 || dataOUT !== exp) begin
        n_fail++;
        $display("FAIL reset_vs_write_read addr=%0d got=%h exp=0", addr, dataOUT);
      end
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 4'd0, 4'h1);
    drive(1'b1, 1'b1, 4'd15, 4'hE);
    drive(1'b1, 1'b1, 4'd0, 4'h3);
    exp = exp_q.pop_front();
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    drive(1'b1, 1'b0, 4'd0, 4'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (dataOUT !== 4'h3 || dataOUT !== exp) begin
      n_fail++;
      $display("FAIL b2b_addr0 got=%h exp=3", dataOUT);
    end
    drive(1'b1, 1'b0, 4'd15, 4'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if (dataOUT !== 4'hE || dataOUT !== exp) begin
      n_fail++;
      $display("FAIL b2b_addr15 got=%h exp=e", dataOUT);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; WR = 1'b0; addr = 4'h0; dataIN = 4'h0;
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    test_reset();
    test_fill();
    test_read_during_write();
    test_write_disabled();
    test_reset_beats_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
